// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared state and PC-select encodings for the pipeline controller
package pipe_ctrl_pkg;
   typedef logic [2:0] state_t;
   localparam state_t ST_RUN       = 3'd0;
   localparam state_t ST_RET_WAIT  = 3'd1;
   localparam state_t ST_INT_PC    = 3'd2;
   localparam state_t ST_INT_FLAGS = 3'd3;
   localparam state_t ST_INT_VEC   = 3'd4;
   localparam logic [1:0] PC_NEXT   = 2'b00;
   localparam logic [1:0] PC_BRANCH = 2'b01;
   localparam logic [1:0] PC_POP    = 2'b10;
   localparam logic [1:0] PC_VEC    = 2'b11;
endpackage

// File: rtl/ret_wait_cnt.sv
// ret_wait_cnt: 4-bit RET wait counter with clear, increment and terminal compare
module ret_wait_cnt #(
   parameter int MAX = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic inc,
   output logic done
);
   logic [3:0] cnt;
   always_ff @(posedge clk)
      if (reset || clr) cnt <= '0;
      else if (inc) cnt <= cnt + 4'd1;
   assign done = cnt == 4'(MAX - 1);
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline stall/flush/PC-select controller with RET wait and interrupt entry
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int MAX_RET_WAIT = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       hazard_stall,
   input  logic       branch_taken_alu,
   input  logic       ret_decode,
   input  logic       rti_decode,
   input  logic       pc_valid_mem,
   input  logic       int_req,
   output logic       pc_enable,
   output logic       if_id_enable,
   output logic       if_id_flush,
   output logic       id_ex_flush,
   output logic [1:0] pc_src_sel,
   output logic       int_push_pc,
   output logic       int_push_flags,
   output logic       int_ack,
   output logic       busy,
   output logic       ret_timeout
);
   state_t state, state_nxt;
   logic int_en, is_rti, ret_take, rti_done, timeout, cnt_inc, cnt_done;
   ret_wait_cnt #(.MAX(MAX_RET_WAIT)) u_cnt (
      .clk(clk), .reset(reset), .clr(ret_take), .inc(cnt_inc), .done(cnt_done)
   );
   always_comb begin
      pc_enable = 1'b1;
      if_id_enable = 1'b1;
      if_id_flush = 1'b0;
      id_ex_flush = 1'b0;
      pc_src_sel = PC_NEXT;
      int_push_pc = 1'b0;
      int_push_flags = 1'b0;
      int_ack = 1'b0;
      busy = state != ST_RUN;
      state_nxt = state;
      ret_take = 1'b0;
      rti_done = 1'b0;
      timeout = 1'b0;
      cnt_inc = 1'b0;
      case (state)
         ST_RUN:
            if (branch_taken_alu) begin
               if_id_flush = 1'b1;
               id_ex_flush = 1'b1;
               pc_src_sel = PC_BRANCH;
            end else if (hazard_stall) begin
               pc_enable = 1'b0;
               if_id_enable = 1'b0;
               id_ex_flush = 1'b1;
            end else if (int_req && int_en) begin
               pc_enable = 1'b0;
               if_id_flush = 1'b1;
               state_nxt = ST_INT_PC;
            end else if (ret_decode) begin
               pc_enable = 1'b0;
               if_id_flush = 1'b1;
               ret_take = 1'b1;
               state_nxt = ST_RET_WAIT;
            end
         ST_RET_WAIT: begin
            if_id_flush = 1'b1;
            cnt_inc = 1'b1;
            pc_enable = pc_valid_mem || cnt_done;
            pc_src_sel = pc_valid_mem ? PC_POP : PC_NEXT;
            rti_done = pc_valid_mem && is_rti;
            timeout = !pc_valid_mem && cnt_done;
            state_nxt = (pc_valid_mem || cnt_done) ? ST_RUN : ST_RET_WAIT;
         end
         ST_INT_PC: begin
            int_push_pc = 1'b1;
            pc_enable = 1'b0;
            if_id_flush = 1'b1;
            state_nxt = ST_INT_FLAGS;
         end
         ST_INT_FLAGS: begin
            int_push_flags = 1'b1;
            pc_enable = 1'b0;
            if_id_flush = 1'b1;
            state_nxt = ST_INT_VEC;
         end
         ST_INT_VEC: begin
            pc_src_sel = PC_VEC;
            int_ack = 1'b1;
            state_nxt = ST_RUN;
         end
         default: state_nxt = ST_RUN;
      endcase
      // reset holds the pipeline frozen and flushed regardless of state
      if (reset) begin
         pc_enable = 1'b0;
         if_id_enable = 1'b0;
         if_id_flush = 1'b1;
         id_ex_flush = 1'b1;
         pc_src_sel = PC_NEXT;
         int_push_pc = 1'b0;
         int_push_flags = 1'b0;
         int_ack = 1'b0;
         busy = 1'b0;
      end
   end
   always_ff @(posedge clk)
      if (reset) begin
         state <= ST_RUN;
         int_en <= 1'b1;
         is_rti <= 1'b0;
         ret_timeout <= 1'b0;
      end else begin
         state <= state_nxt;
         if (ret_take) is_rti <= rti_decode;
         if (rti_done) int_en <= 1'b1;
         else if (state == ST_INT_VEC) int_en <= 1'b0;
         if (timeout) ret_timeout <= 1'b1;
      end
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed and randomized checks of pipe_ctrl against a behavioural model
module tb_pipe_ctrl;
   localparam int MAXW = 4;
   logic clk = 1'b0;
   logic reset, hazard_stall, branch_taken_alu, ret_decode, rti_decode, pc_valid_mem, int_req;
   logic pc_enable, if_id_enable, if_id_flush, id_ex_flush;
   logic [1:0] pc_src_sel;
   logic int_push_pc, int_push_flags, int_ack, busy, ret_timeout;
   logic [10:0] obs;
   int checks = 0;
   int errors = 0;
   int m_ret = -1;
   int m_int = 0;
   bit m_ie = 1'b1;
   bit m_rti = 1'b0;
   bit m_tmo = 1'b0;

   always #5 clk = ~clk;

   pipe_ctrl #(.MAX_RET_WAIT(MAXW)) dut (
      .clk(clk), .reset(reset), .hazard_stall(hazard_stall), .branch_taken_alu(branch_taken_alu),
      .ret_decode(ret_decode), .rti_decode(rti_decode), .pc_valid_mem(pc_valid_mem), .int_req(int_req),
      .pc_enable(pc_enable), .if_id_enable(if_id_enable), .if_id_flush(if_id_flush),
      .id_ex_flush(id_ex_flush), .pc_src_sel(pc_src_sel), .int_push_pc(int_push_pc),
      .int_push_flags(int_push_flags), .int_ack(int_ack), .busy(busy), .ret_timeout(ret_timeout)
   );

   assign obs = {pc_enable, if_id_enable, if_id_flush, id_ex_flush, pc_src_sel,
                 int_push_pc, int_push_flags, int_ack, busy, ret_timeout};

   // m_int counts cycles since an interrupt was accepted; m_ret counts RET_WAIT cycles spent
   function automatic logic [10:0] model_out();
      logic pe = 1'b1, ie = 1'b1, ifl = 1'b0, efl = 1'b0, pp = 1'b0, pf = 1'b0, ack = 1'b0, bsy = 1'b0;
      logic [1:0] src = 2'd0;
      if (reset) begin
         pe = 0; ie = 0; ifl = 1; efl = 1;
      end else if (m_int == 1) begin
         pp = 1; pe = 0; ifl = 1; bsy = 1;
      end else if (m_int == 2) begin
         pf = 1; pe = 0; ifl = 1; bsy = 1;
      end else if (m_int == 3) begin
         ack = 1; src = 2'd3; bsy = 1;
      end else if (m_ret >= 0) begin
         bsy = 1; ifl = 1;
         pe = pc_valid_mem || (m_ret == MAXW - 1);
         src = pc_valid_mem ? 2'd2 : 2'd0;
      end else if (branch_taken_alu) begin
         ifl = 1; efl = 1; src = 2'd1;
      end else if (hazard_stall) begin
         pe = 0; ie = 0; efl = 1;
      end else if ((int_req && m_ie) || ret_decode) begin
         pe = 0; ifl = 1;
      end
      return {pe, ie, ifl, efl, src, pp, pf, ack, bsy, m_tmo};
   endfunction

   function automatic void model_adv();
      if (reset) begin
         m_ret = -1; m_int = 0; m_ie = 1; m_rti = 0; m_tmo = 0;
      end else if (m_int != 0) begin
         if (m_int == 3) m_ie = 0;
         m_int = (m_int == 3) ? 0 : m_int + 1;
      end else if (m_ret >= 0) begin
         if (pc_valid_mem) begin
            if (m_rti) m_ie = 1;
            m_ret = -1;
         end else if (m_ret == MAXW - 1) begin
            m_tmo = 1; m_ret = -1;
         end else m_ret++;
      end else if (!branch_taken_alu && !hazard_stall) begin
         if (int_req && m_ie) m_int = 1;
         else if (ret_decode) begin
            m_ret = 0; m_rti = rti_decode;
         end
      end
   endfunction

   task automatic set_in(input logic r, st, br, rd, rti, pv, ir);
      reset = r; hazard_stall = st; branch_taken_alu = br; ret_decode = rd;
      rti_decode = rti; pc_valid_mem = pv; int_req = ir;
      #1;
   endtask

   task automatic step();
      @(posedge clk);
      model_adv();
      @(negedge clk);
   endtask

   task automatic test_reset();
      for (int i = 0; i < 2; i++) begin
         set_in(1, 1, 1, 1, 1, 1, 1);
         checks++;
         if (obs !== 11'b0011_00_000_0_0) begin
            errors++; $display("FAIL reset_out c%0d: got %b expected %b", i, obs, 11'b0011_00_000_0_0);
         end
         step();
      end
      set_in(0, 0, 0, 0, 0, 0, 0);
      checks++;
      if (obs !== 11'b1100_00_000_0_0) begin
         errors++; $display("FAIL reset_idle: got %b expected %b", obs, 11'b1100_00_000_0_0);
      end
      step();
   endtask

   task automatic test_stall();
      for (int i = 0; i < 3; i++) begin
         set_in(0, i < 2, 0, 0, 0, 0, 0);
         checks++;
         if ({pc_enable, if_id_enable, id_ex_flush} !== ((i < 2) ? 3'b001 : 3'b110)) begin
            errors++; $display("FAIL stall c%0d: got %b expected %b", i,
                               {pc_enable, if_id_enable, id_ex_flush}, (i < 2) ? 3'b001 : 3'b110);
         end
         step();
      end
   endtask

   task automatic test_branch_stall();
      set_in(0, 1, 1, 1, 0, 0, 1);
      checks++;
      if (obs !== 11'b1111_01_000_0_0) begin
         errors++; $display("FAIL branch_stall: got %b expected %b", obs, 11'b1111_01_000_0_0);
      end
      step();
      set_in(0, 0, 0, 0, 0, 0, 0);
      checks++;
      if (busy !== 1'b0) begin
         errors++; $display("FAIL branch_stays_run: got %b expected 0", busy);
      end
      step();
   endtask

   task automatic test_interrupt();
      for (int i = 0; i < 8; i++) begin
         set_in(0, 0, 0, 0, 0, 0, (i == 0) || (i >= 4));
         checks++;
         if (obs !== model_out()) begin
            errors++; $display("FAIL int_model c%0d: got %b expected %b", i, obs, model_out());
         end
         checks++;
         if ({int_push_pc, int_push_flags, int_ack} !== ((i == 1) ? 3'b100 : (i == 2) ? 3'b010 : (i == 3) ? 3'b001 : 3'b000)) begin
            errors++; $display("FAIL int_timing c%0d: got %b", i, {int_push_pc, int_push_flags, int_ack});
         end
         if (i == 3) begin
            checks++;
            if (pc_src_sel !== 2'b11) begin
               errors++; $display("FAIL int_vec_sel: got %b expected 11", pc_src_sel);
            end
         end
         step();
      end
   endtask

   task automatic test_rti();
      for (int i = 0; i < 5; i++) begin
         set_in(0, 0, 0, i == 0, i == 0, i == 2, i == 4);
         checks++;
         if (obs !== model_out()) begin
            errors++; $display("FAIL rti_model c%0d: got %b expected %b", i, obs, model_out());
         end
         if (i == 2) begin
            checks++;
            if (pc_src_sel !== 2'b10 || pc_enable !== 1'b1) begin
               errors++; $display("FAIL rti_pop: got sel %b en %b expected 10 1", pc_src_sel, pc_enable);
            end
         end
         step();
      end
      set_in(0, 0, 0, 0, 0, 0, 0);
      checks++;
      if (int_push_pc !== 1'b1) begin
         errors++; $display("FAIL rti_reenable: got %b expected 1", int_push_pc);
      end
      for (int i = 0; i < 3; i++) step();
   endtask

   task automatic test_timeout();
      int waits = 0;
      set_in(0, 0, 0, 1, 0, 0, 0);
      step();
      set_in(0, 0, 0, 0, 0, 0, 0);
      while (busy && waits < 20) begin
         checks++;
         if (obs !== model_out()) begin
            errors++; $display("FAIL timeout_model c%0d: got %b expected %b", waits, obs, model_out());
         end
         waits++;
         step();
      end
      checks++;
      if (waits != MAXW || ret_timeout !== 1'b1 || busy !== 1'b0) begin
         errors++; $display("FAIL timeout: got %0d waits flag %b busy %b expected %0d 1 0", waits, ret_timeout, busy, MAXW);
      end
   endtask

   task automatic test_reset_mid();
      int acks = 0;
      set_in(1, 0, 0, 0, 0, 0, 0);
      step();
      set_in(0, 0, 0, 0, 0, 0, 1);
      step();
      set_in(0, 0, 0, 0, 0, 0, 0);
      step();
      checks++;
      if (int_push_flags !== 1'b1) begin
         errors++; $display("FAIL mid_flags: got %b expected 1", int_push_flags);
      end
      for (int i = 0; i < 3; i++) begin
         set_in(1, 0, 0, 0, 0, 0, 0);
         if (int_ack || int_push_pc || int_push_flags) acks++;
         step();
      end
      set_in(0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         if (int_ack || int_push_pc || int_push_flags) acks++;
         step();
      end
      checks++;
      if (acks != 0 || busy !== 1'b0) begin
         errors++; $display("FAIL mid_reset_abandon: got %0d strobes busy %b expected 0 0", acks, busy);
      end
      set_in(0, 0, 0, 0, 0, 0, 1);
      step();
      checks++;
      if (int_push_pc !== 1'b1) begin
         errors++; $display("FAIL mid_reset_int_en: got %b expected 1", int_push_pc);
      end
      set_in(0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 2; i++) step();
   endtask

   task automatic test_random();
      for (int i = 0; i < 600; i++) begin
         set_in($urandom_range(0, 39) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 5) == 0,
                $urandom_range(0, 3) == 0, $urandom_range(0, 1), $urandom_range(0, 3) == 0,
                $urandom_range(0, 4) == 0);
         checks++;
         if (obs !== model_out()) begin
            errors++; $display("FAIL random c%0d: got %b expected %b", i, obs, model_out());
         end
         step();
      end
   endtask

   initial begin
      set_in(1, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      test_reset();
      test_stall();
      test_branch_stall();
      test_interrupt();
      test_rti();
      test_timeout();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
